// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm recorder and the player datapath:
// map length, counter width and recorder state encoding.
package rhythm_pkg;

   localparam int MAP_LEN_DEF = 191;
   localparam int CNT_W_DEF   = 8;
   localparam int PREVIEW_W   = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } rec_state_t;

endpackage

// File: rtl/press_detector.sv
// Player key conditioning: two-flop synchronizer on the active-low key,
// then a registered falling-edge detect that gives one pulse per press.
module press_detector (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic press
);

   logic sync1;
   logic sync2;
   logic prev;

   // Released key reads high, so every stage resets high to avoid a false press.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
         press <= 1'b0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         prev  <= sync2;
         press <= prev & ~sync2;
      end
   end

endmodule

// File: rtl/rhythm_recorder.sv
// Records key presses into a tick-slotted rhythm map; the newest slot enters
// at the top so a right-shifting player replays slot 0 first.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start, map cleared by reset
// ST_RECORD | latching presses, committing one slot per tick
// ST_FLUSH  | padding zeros each clk until the map is full
// ST_DONE   | map frozen and valid; start begins a new recording
module rhythm_recorder
   import rhythm_pkg::*;
#(
   parameter int MAP_LEN = MAP_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 button,
   input  logic                 start,
   input  logic                 stop,
   output logic [MAP_LEN-1:0]   rhythm_map,
   output logic [CNT_W-1:0]     slot_count,
   output logic [CNT_W-1:0]     note_count,
   output logic                 recording,
   output logic                 done,
   output logic [PREVIEW_W-1:0] preview
);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(MAP_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   rec_state_t state;
   logic       press;
   logic       latch_q;
   logic       commit_bit;
   logic       last_slot;

   press_detector u_press_detector (
      .clk    (clk),
      .rst    (rst),
      .button (button),
      .press  (press)
   );

   // A press arriving with the tick belongs to the slot being committed.
   assign commit_bit = latch_q | press;
   assign last_slot  = (slot_count == SLOT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rhythm_map <= '0;
         slot_count <= '0;
         note_count <= '0;
         latch_q    <= 1'b0;
         recording  <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_RECORD;
                  rhythm_map <= '0;
                  slot_count <= '0;
                  note_count <= '0;
                  latch_q    <= 1'b0;
                  recording  <= 1'b1;
                  done       <= 1'b0;
               end
            end
            ST_RECORD: begin
               if (tick) begin
                  rhythm_map <= {commit_bit, rhythm_map[MAP_LEN-1:1]};
                  slot_count <= slot_count + CNT_ONE;
                  if (commit_bit) note_count <= note_count + CNT_ONE;
                  latch_q <= 1'b0;
                  if (last_slot) begin
                     state     <= ST_DONE;
                     recording <= 1'b0;
                     done      <= 1'b1;
                  end else if (stop) begin
                     state     <= ST_FLUSH;
                     recording <= 1'b0;
                  end
               end else if (stop) begin
                  latch_q   <= 1'b0;
                  state     <= ST_FLUSH;
                  recording <= 1'b0;
               end else if (press) begin
                  latch_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               // Padding keeps partial maps aligned with slot 0 at bit 0.
               rhythm_map <= {1'b0, rhythm_map[MAP_LEN-1:1]};
               slot_count <= slot_count + CNT_ONE;
               if (last_slot) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               recording <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (MAP_LEN >= PREVIEW_W) begin : g_preview_full
         assign preview = rhythm_map[MAP_LEN-1 -: PREVIEW_W];
      end else begin : g_preview_short
         assign preview = {rhythm_map, {(PREVIEW_W-MAP_LEN){1'b0}}};
      end
   endgenerate

endmodule

// File: tb/tb_rhythm_recorder.sv
// Bench for rhythm_recorder at MAP_LEN = 8: scenario table, corner sequences,
// and a randomized run against a slot-list reference model.
module tb_rhythm_recorder;

   localparam int ML = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst, tick, button, start, stop;
   logic [ML-1:0] rhythm_map;
   logic [CW-1:0] slot_count, note_count;
   logic          recording, done;
   logic [9:0]    preview;

   rhythm_recorder #(.MAP_LEN(ML), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .button     (button),
      .start      (start),
      .stop       (stop),
      .rhythm_map (rhythm_map),
      .slot_count (slot_count),
      .note_count (note_count),
      .recording  (recording),
      .done       (done),
      .preview    (preview)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 record, 2 flush, 3 done.
   int m_mode = 0;
   bit m_slots[$];
   bit m_latch = 0;
   bit h1 = 1, h2 = 1, h3 = 1, h4 = 1;

   typedef struct {
      logic [7:0] press_mask;
      int         press_n;
      int         stop_at;
      logic [7:0] exp_map;
      int         exp_notes;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [ML-1:0] m_map();
      logic [ML-1:0] m;
      int n;
      m = '0;
      n = m_slots.size();
      for (int i = 0; i < n; i++) m[ML-n+i] = m_slots[i];
      return m;
   endfunction

   function automatic int m_notes();
      int c = 0;
      foreach (m_slots[i]) if (m_slots[i]) c++;
      return c;
   endfunction

   function automatic logic [9:0] m_preview();
      logic [9:0]    p;
      logic [ML-1:0] m;
      m = m_map();
      p = '0;
      for (int k = 0; k < 10; k++) if (ML - 1 - k >= 0) p[9-k] = m[ML-1-k];
      return p;
   endfunction

   // Key sampled low at edge e shows up as a press at edge e+3.
   task automatic model_edge(input bit t, input bit b, input bit s, input bit sp, input bit r);
      bit p;
      p  = h4 & ~h3;
      h4 = h3; h3 = h2; h2 = h1; h1 = b;
      if (r) begin
         m_mode = 0; m_slots.delete(); m_latch = 0;
         h1 = 1; h2 = 1; h3 = 1; h4 = 1;
      end else begin
         case (m_mode)
            0, 3: if (s) begin m_mode = 1; m_slots.delete(); m_latch = 0; end
            1: begin
               if (t) begin
                  m_slots.push_back(m_latch | p);
                  m_latch = 0;
                  if (m_slots.size() == ML) m_mode = 3;
                  else if (sp) m_mode = 2;
               end else if (sp) begin
                  m_latch = 0; m_mode = 2;
               end else if (p) m_latch = 1;
            end
            2: begin
               m_slots.push_back(1'b0);
               if (m_slots.size() == ML) m_mode = 3;
            end
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic step(input bit t, input bit b, input bit s, input bit sp, input bit r);
      tick = t; button = b; start = s; stop = sp; rst = r;
      @(posedge clk);
      model_edge(t, b, s, sp, r);
      #1;
   endtask

   task automatic idle();            step(0, 1, 0, 0, 0); endtask
   task automatic do_tick();         idle(); step(1, 1, 0, 0, 0); endtask
   task automatic press_key();
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_map"},     rhythm_map, m_map());
      chk({tag, "_slots"},   slot_count, m_slots.size());
      chk({tag, "_notes"},   note_count, m_notes());
      chk({tag, "_rec"},     recording, m_mode == 1);
      chk({tag, "_done"},    done, m_mode == 3);
      chk({tag, "_preview"}, preview, m_preview());
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cycles;
      string tag;
      tag = $sformatf("vec%0d", idx);
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 0);
      for (int s = 0; s < ML; s++) begin
         if (s == v.stop_at) break;
         if (v.press_mask[s]) repeat (v.press_n) press_key();
         do_tick();
      end
      if (v.stop_at < ML) begin
         step(0, 1, 0, 1, 0);
         cycles = 0;
         while (done !== 1'b1 && cycles < 20) begin
            idle();
            cycles++;
         end
         chk({tag, "_flush_cycles"}, cycles, ML - v.stop_at);
      end
      chk({tag, "_map"},   rhythm_map, v.exp_map);
      chk({tag, "_notes"}, note_count, v.exp_notes);
      chk({tag, "_slots"}, slot_count, ML);
      chk({tag, "_done"},  done, 1);
      chk({tag, "_rec"},   recording, 0);
      chk({tag, "_preview"}, preview, {v.exp_map, 2'b00});
   endtask

   vec_t vecs[6];

   initial begin
      bit b_state;
      tick = 0; button = 1; start = 0; stop = 0; rst = 1;

      vecs[0] = '{8'b1000_1001, 1, 8, 8'b1000_1001, 3};
      vecs[1] = '{8'b0000_0100, 3, 8, 8'b0000_0100, 1};
      vecs[2] = '{8'b0000_0010, 1, 3, 8'b0000_0010, 1};
      vecs[3] = '{8'b1111_1111, 2, 8, 8'b1111_1111, 8};
      vecs[4] = '{8'b0000_0000, 1, 0, 8'b0000_0000, 0};
      vecs[5] = '{8'b0010_0101, 1, 5, 8'b0000_0101, 2};

      // Reset state
      step(0, 1, 0, 0, 1);
      chk("reset_map", rhythm_map, 0);
      chk("reset_slots", slot_count, 0);
      chk("reset_notes", note_count, 0);
      chk("reset_rec", recording, 0);
      chk("reset_done", done, 0);
      chk("reset_preview", preview, 0);

      // Idle ignores ticks, stop, presses
      do_tick(); step(0, 1, 0, 1, 0); press_key(); do_tick();
      chk("idle_slots", slot_count, 0);
      chk("idle_rec", recording, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // DONE holds map; start clears
      run_vec(vecs[0], 10);
      do_tick(); press_key(); step(0, 1, 0, 1, 0); do_tick();
      chk("done_hold_map", rhythm_map, 8'b1000_1001);
      chk("done_hold_slots", slot_count, 8);
      chk("done_hold_done", done, 1);
      step(0, 1, 1, 0, 0);
      chk("restart_map", rhythm_map, 0);
      chk("restart_rec", recording, 1);
      chk("restart_done", done, 0);
      chk("restart_slots", slot_count, 0);
      // start in RECORD ignored
      press_key(); do_tick(); step(0, 1, 1, 0, 0); do_tick();
      chk("rec_start_ignored_slots", slot_count, 2);
      chk("rec_start_ignored_map", rhythm_map, 8'b0100_0000);

      // Press coincident with tick 4; stop coincident with tick 8
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 0);
      repeat (4) do_tick();
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
      do_tick(); do_tick();
      idle(); step(1, 1, 0, 1, 0);
      chk("coinc_map", rhythm_map, 8'b0001_0000);
      chk("coinc_bit4", rhythm_map[4], 1);
      chk("coinc_bit5", rhythm_map[5], 0);
      chk("coinc_done_now", done, 1);
      chk("coinc_slots", slot_count, 8);
      chk("coinc_notes", note_count, 1);

      // Reset mid-RECORD
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 0);
      for (int s = 0; s < 5; s++) begin
         if (s == 2) press_key();
         do_tick();
      end
      chk("pre_rst_slots", slot_count, 5);
      step(0, 1, 0, 0, 1);
      chk("midrst_map", rhythm_map, 0);
      chk("midrst_slots", slot_count, 0);
      chk("midrst_notes", note_count, 0);
      chk("midrst_rec", recording, 0);
      chk("midrst_done", done, 0);
      chk("midrst_preview", preview, 0);
      repeat (3) do_tick();
      chk("midrst_later_slots", slot_count, 0);

      // Reset mid-FLUSH
      step(0, 1, 1, 0, 0);
      press_key(); do_tick();
      step(0, 1, 0, 1, 0); idle();
      step(0, 1, 0, 0, 1);
      chk("flushrst_map", rhythm_map, 0);
      chk("flushrst_slots", slot_count, 0);
      chk("flushrst_done", done, 0);

      // Randomized run against the model
      step(0, 1, 0, 0, 1);
      b_state = 1;
      for (int c = 0; c < 4000; c++) begin
         bit r, s, sp, t;
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 24) == 0);
         sp = ($urandom_range(0, 49) == 0);
         t  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) b_state = ~b_state;
         step(t, b_state, s, sp, r);
         check_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
